// File: rtl/alu.sv
// Single-cycle registered ALU: add/sub with carry, rotates, logic ops, A==B flag.
// Optional rotator gated by `ALU_ROT_EN; when it is undefined, the rotate codes pass a_in through.
module alu #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic [2:0]       func_code,
    output logic [WIDTH-1:0] a_out,
    output logic             carry_out,
    output logic             equ_out,
    output logic             overflow_out
);
    localparam int AW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_ROTL = 3'b010,
        OP_ROTR = 3'b011,
        OP_XOR  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_NOT  = 3'b111
    } op_e;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH-1:0] res_d;
    logic             carry_d, ovf_d;

    assign sum  = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, carry_in};
    assign diff = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, carry_in};

`ifdef ALU_ROT_EN
    logic [AW-1:0]      rot_raw, rot_amt;
    logic [2*WIDTH-1:0] rot_dbl, rot_shl, rot_shr;

    // Amount field spans < 2*WIDTH, so one conditional subtract gives mod WIDTH.
    assign rot_raw = b_in[AW-1:0];
    assign rot_amt = (rot_raw >= AW'(WIDTH)) ? rot_raw - AW'(WIDTH) : rot_raw;
    assign rot_dbl = {a_in, a_in};
    assign rot_shl = rot_dbl << rot_amt;
    assign rot_shr = rot_dbl >> rot_amt;
    assign rot_l   = rot_shl[2*WIDTH-1:WIDTH];
    assign rot_r   = rot_shr[WIDTH-1:0];
`else
    assign rot_l = a_in;
    assign rot_r = a_in;
`endif

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (op_e'(func_code))
            OP_ADD: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                res_d   = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];
                ovf_d   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (diff[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_ROTL: res_d = rot_l;
            OP_ROTR: res_d = rot_r;
            OP_XOR:  res_d = a_in ^ b_in;
            OP_AND:  res_d = a_in & b_in;
            OP_OR:   res_d = a_in | b_in;
            OP_NOT:  res_d = ~a_in;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out        <= '0;
            carry_out    <= 1'b0;
            equ_out      <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            a_out        <= res_d;
            carry_out    <= carry_d;
            equ_out      <= (a_in == b_in);
            overflow_out <= ovf_d;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table plus random ops with a mid-stream async reset.
// Expected results queue up when driven and are compared one cycle later.
module tb_alu;
    logic        clk, rst_n;
    logic [11:0] a_in, b_in;
    logic        carry_in;
    logic [2:0]  func_code;
    logic [11:0] a_out;
    logic        carry_out, equ_out, overflow_out;

`ifdef ALU_ROT_EN
    localparam bit ROT_ON = 1'b1;
`else
    localparam bit ROT_ON = 1'b0;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [11:0] a, b;
        logic        cin;
        logic [11:0] r;
        logic        c, e, o;
    } vec_t;

    typedef struct {
        int          id;
        logic [11:0] r;
        logic        c, e, o;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    alu #(.WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
        .func_code(func_code), .a_out(a_out), .carry_out(carry_out),
        .equ_out(equ_out), .overflow_out(overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int id, input logic [2:0] f, input logic [11:0] a,
                                   input logic [11:0] b, input logic cin);
        exp_t x;
        int   s;
        int   n;
        x.id = id; x.r = '0; x.c = 1'b0; x.o = 1'b0;
        x.e  = (a == b);
        case (f)
            3'd0: begin
                s = int'(a) + int'(b) + int'(cin);
                x.r = s[11:0]; x.c = s[12];
                x.o = (a[11] == b[11]) && (x.r[11] != a[11]);
            end
            3'd1: begin
                s = int'(a) - int'(b) - int'(cin);
                if (s < 0) s = s + 8192;
                x.r = s[11:0]; x.c = s[12];
                x.o = (a[11] != b[11]) && (x.r[11] != a[11]);
            end
            3'd2, 3'd3: begin
                x.r = a;
                n = ROT_ON ? int'(b[3:0]) % 12 : 0;
                for (int i = 0; i < n; i++)
                    x.r = (f == 3'd2) ? {x.r[10:0], x.r[11]} : {x.r[0], x.r[11:1]};
            end
            3'd4: x.r = a ^ b;
            3'd5: x.r = a & b;
            3'd6: x.r = a | b;
            default: x.r = ~a;
        endcase
        return x;
    endfunction

    task automatic check_pending();
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (a_out !== x.r || carry_out !== x.c || equ_out !== x.e || overflow_out !== x.o) begin
                failures++;
                $display("FAIL op%0d: got r=%h c=%b e=%b o=%b, want r=%h c=%b e=%b o=%b",
                         x.id, a_out, carry_out, equ_out, overflow_out, x.r, x.c, x.e, x.o);
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (a_out !== 12'h000 || carry_out !== 1'b0 || equ_out !== 1'b0 || overflow_out !== 1'b0) begin
            failures++;
            $display("FAIL %s: got r=%h c=%b e=%b o=%b, want all zero",
                     name, a_out, carry_out, equ_out, overflow_out);
        end
    endtask

    task automatic step(input logic [2:0] f, input logic [11:0] a, input logic [11:0] b,
                        input logic cin, input exp_t x);
        @(negedge clk);
        check_pending();
        func_code = f; a_in = a; b_in = b; carry_in = cin;
        q.push_back(x);
    endtask

    vec_t vt[$];

    initial begin
        exp_t x;
        logic [2:0]  rf;
        logic [11:0] ra, rb;
        logic        rc;

        vt = '{
            '{3'd0, 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b0, 1'b1},
            '{3'd0, 12'h800, 12'hFFF, 1'b1, 12'h800, 1'b1, 1'b0, 1'b0},
            '{3'd0, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0},
            '{3'd1, 12'h123, 12'h456, 1'b1, 12'hCCC, 1'b1, 1'b0, 1'b0},
            '{3'd1, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0},
            '{3'd1, 12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b0, 1'b1},
            '{3'd2, 12'hC00, 12'h001, 1'b1, ROT_ON ? 12'h801 : 12'hC00, 1'b0, 1'b0, 1'b0},
            '{3'd3, 12'h001, 12'h001, 1'b0, ROT_ON ? 12'h800 : 12'h001, 1'b0, 1'b1, 1'b0},
            '{3'd2, 12'hFFF, 12'h004, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0},
            '{3'd3, 12'h123, 12'h00C, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0},
            '{3'd3, 12'h001, 12'h00F, 1'b0, ROT_ON ? 12'h200 : 12'h001, 1'b0, 1'b0, 1'b0},
            '{3'd2, 12'hA5A, 12'h0F3, 1'b1, ROT_ON ? 12'h2D5 : 12'hA5A, 1'b0, 1'b0, 1'b0},
            '{3'd4, 12'hAAA, 12'h555, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0},
            '{3'd5, 12'hFFF, 12'h555, 1'b1, 12'h555, 1'b0, 1'b0, 1'b0},
            '{3'd6, 12'h000, 12'h555, 1'b0, 12'h555, 1'b0, 1'b0, 1'b0},
            '{3'd7, 12'h000, 12'h000, 1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0}
        };

        // Reset state: equal operands would set equ_out if reset did not hold it.
        rst_n = 1'b0; func_code = 3'd7; a_in = 12'h5A5; b_in = 12'h5A5; carry_in = 1'b1;
        #1 check_zero("reset_initial");
        @(posedge clk); #1 check_zero("reset_held");
        @(negedge clk); rst_n = 1'b1;

        foreach (vt[i]) begin
            x.id = i; x.r = vt[i].r; x.c = vt[i].c; x.e = vt[i].e; x.o = vt[i].o;
            step(vt[i].f, vt[i].a, vt[i].b, vt[i].cin, x);
        end

        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                // Force nonzero outputs, then pull reset between edges.
                step(3'd7, 12'h000, 12'h000, 1'b0, model(1000, 3'd7, 12'h000, 12'h000, 1'b0));
                @(posedge clk); #1 check_pending();
                #2 rst_n = 1'b0;
                #1 check_zero("reset_async_midstream");
                @(posedge clk); #1 check_zero("reset_midstream_held");
                @(negedge clk); rst_n = 1'b1;
            end
            rf = 3'($urandom_range(0, 7));
            ra = 12'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 12'($urandom);
            rc = 1'($urandom);
            step(rf, ra, rb, rc, model(100 + i, rf, ra, rb, rc));
        end
        @(negedge clk);
        check_pending();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
